// File: rtl/branch_resolver_if.sv
// Pipeline <-> branch resolver bundle: IF-stage prediction, EX-stage outcome,
// and the redirect / predictor-update / statistics results.
interface branch_resolver_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             upd_valid;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Pipeline side: drives fetch/execute information, consumes the results.
  modport master (
    output stall, if_valid, if_pc, pred_taken, pred_target,
           ex_is_branch, ex_taken, ex_target,
    input  flush, redirect_valid, redirect_pc,
           upd_valid, upd_taken, upd_pc, upd_target,
           branch_cnt, mispred_cnt
  );

  // Resolver side.
  modport slave (
    input  stall, if_valid, if_pc, pred_taken, pred_target,
           ex_is_branch, ex_taken, ex_target,
    output flush, redirect_valid, redirect_pc,
           upd_valid, upd_taken, upd_pc, upd_target,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: carries each fetched PC's BTB prediction through IF/ID and
// ID/EX, compares it with the EX outcome, and emits a registered flush/redirect,
// a predictor update strobe and saturating branch/mispredict counters.
// rst is asynchronous and active-low.
module branch_resolver #(
  parameter int PC_W      = 8,
  parameter int FLUSH_LEN = 2,   // squash window after a redirect, 1..7
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);

  typedef enum logic {S_RUN = 1'b0, S_SQUASH = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;

  // IF/ID and ID/EX stage registers
  logic             id_valid_reg, ex_valid_reg;
  logic [PC_W-1:0]  id_pc_reg, ex_pc_reg;
  logic             id_pt_reg, ex_pt_reg;
  logic [PC_W-1:0]  id_ptgt_reg, ex_ptgt_reg;

  // Registered outputs
  logic             flush_reg, redirect_valid_reg, upd_valid_reg, upd_taken_reg;
  logic [PC_W-1:0]  redirect_pc_reg, upd_pc_reg, upd_target_reg;

  logic             resolve, mispred;
  logic [PC_W-1:0]  fall_thru, pnext, anext;

  // Compare predicted and actual next PC of the EX instruction
  always_comb begin
    fall_thru = ex_pc_reg + PC_W'(4);
    pnext     = ex_pt_reg ? ex_ptgt_reg : fall_thru;
    anext     = bus.ex_taken ? bus.ex_target : fall_thru;
    resolve   = !bus.stall && (state_reg == S_RUN) && ex_valid_reg && bus.ex_is_branch;
    mispred   = resolve && (pnext != anext);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM next state: a mispredict opens a squash window that only counts down on unstalled cycles
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (mispred) begin
          state_next = S_SQUASH;
          cnt_next   = 3'(FLUSH_LEN);
        end
      end
      S_SQUASH: begin
        if (!bus.stall) begin
          if (cnt_reg == 3'd1) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 3'd1;
          end
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  // Stage registers advance when not stalled; a mispredict kills the younger wrong-path slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_pt_reg    <= 1'b0;
      id_ptgt_reg  <= '0;
      ex_valid_reg <= 1'b0;
      ex_pc_reg    <= '0;
      ex_pt_reg    <= 1'b0;
      ex_ptgt_reg  <= '0;
    end else if (!bus.stall) begin
      id_valid_reg <= bus.if_valid && !mispred;
      id_pc_reg    <= bus.if_pc;
      id_pt_reg    <= bus.pred_taken;
      id_ptgt_reg  <= bus.pred_target;
      ex_valid_reg <= id_valid_reg && !mispred;
      ex_pc_reg    <= id_pc_reg;
      ex_pt_reg    <= id_pt_reg;
      ex_ptgt_reg  <= id_ptgt_reg;
    end
  end

  // Output registers: strobes last one cycle, payloads hold until the next event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      upd_valid_reg      <= 1'b0;
      upd_taken_reg      <= 1'b0;
      upd_pc_reg         <= '0;
      upd_target_reg     <= '0;
    end else begin
      flush_reg          <= mispred;
      redirect_valid_reg <= mispred;
      upd_valid_reg      <= resolve;
      if (mispred) redirect_pc_reg <= anext;
      if (resolve) begin
        upd_taken_reg  <= bus.ex_taken;
        upd_pc_reg     <= ex_pc_reg;
        upd_target_reg <= bus.ex_target;
      end
    end
  end

  // Statistics: index 0 counts resolves, index 1 counts mispredicts
  logic [1:0]            stat_inc;
  logic [1:0][CNT_W-1:0] stat_q;
  assign stat_inc = {mispred, resolve};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic [CNT_W-1:0] count_reg;
    // Saturating event counter
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        count_reg <= '0;
      else if (stat_inc[gi] && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + CNT_W'(1);
    end
    assign stat_q[gi] = count_reg;
  end

  assign bus.flush          = flush_reg;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.upd_valid      = upd_valid_reg;
  assign bus.upd_taken      = upd_taken_reg;
  assign bus.upd_pc         = upd_pc_reg;
  assign bus.upd_target     = upd_target_reg;
  assign bus.branch_cnt     = stat_q[0];
  assign bus.mispred_cnt    = stat_q[1];

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: a default-width instance (FLUSH_LEN=2, CNT_W=16) and a
// narrow instance (FLUSH_LEN=4, CNT_W=3) share one stimulus so that a longer squash
// window and counter saturation are reachable in a short run.
module tb_branch_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, if_valid, pred_taken, ex_is_branch, ex_taken;
  logic [7:0] if_pc, pred_target, ex_target;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolver_if #(.PC_W(8), .CNT_W(16)) bus_a ();
  branch_resolver_if #(.PC_W(8), .CNT_W(3))  bus_b ();

  assign bus_a.stall = stall;         assign bus_b.stall = stall;
  assign bus_a.if_valid = if_valid;   assign bus_b.if_valid = if_valid;
  assign bus_a.if_pc = if_pc;         assign bus_b.if_pc = if_pc;
  assign bus_a.pred_taken = pred_taken;   assign bus_b.pred_taken = pred_taken;
  assign bus_a.pred_target = pred_target; assign bus_b.pred_target = pred_target;
  assign bus_a.ex_is_branch = ex_is_branch; assign bus_b.ex_is_branch = ex_is_branch;
  assign bus_a.ex_taken = ex_taken;   assign bus_b.ex_taken = ex_taken;
  assign bus_a.ex_target = ex_target; assign bus_b.ex_target = ex_target;

  branch_resolver #(.PC_W(8), .FLUSH_LEN(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  branch_resolver #(.PC_W(8), .FLUSH_LEN(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct {
    logic       iv;      // if_valid when injected
    logic       br;      // ex_is_branch when in EX
    logic [7:0] pc;
    logic       pt;
    logic [7:0] ptgt;
    logic       et;
    logic [7:0] etgt;
    logic       e_upd;
    logic       e_flush;
    logic [7:0] e_rpc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case something stalls the stimulus thread
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_br, exp_mis;
    logic ea, eb;

    //          iv    br    pc     pt    ptgt   et    etgt   upd   flush rpc
    tbl[0] = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00}; // correct taken
    tbl[1] = '{1'b1, 1'b1, 8'h20, 1'b1, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 8'h24}; // direction miss
    tbl[2] = '{1'b1, 1'b1, 8'h30, 1'b1, 8'h50, 1'b1, 8'h60, 1'b1, 1'b1, 8'h60}; // target miss
    tbl[3] = '{1'b1, 1'b1, 8'hFC, 1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 1'b1, 8'h00}; // wrap
    tbl[4] = '{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00}; // correct not taken
    tbl[5] = '{1'b1, 1'b1, 8'h50, 1'b0, 8'h00, 1'b1, 8'h54, 1'b1, 1'b0, 8'h00}; // taken to pc+4
    tbl[6] = '{1'b1, 1'b1, 8'h60, 1'b1, 8'h64, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // pred target = pc+4
    tbl[7] = '{1'b1, 1'b1, 8'h70, 1'b0, 8'h00, 1'b1, 8'h90, 1'b1, 1'b1, 8'h90}; // missed taken
    tbl[8] = '{1'b0, 1'b1, 8'h80, 1'b1, 8'h90, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00}; // bubble
    tbl[9] = '{1'b1, 1'b0, 8'h84, 1'b1, 8'h90, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00}; // not a branch

    rst = 1'b0; stall = 1'b0; if_valid = 1'b0; if_pc = '0; pred_taken = 1'b0;
    pred_target = '0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    repeat (2) tick();

    chk("rst_flush",    32'(bus_a.flush), 0);
    chk("rst_redir_v",  32'(bus_a.redirect_valid), 0);
    chk("rst_redir_pc", 32'(bus_a.redirect_pc), 0);
    chk("rst_upd_v",    32'(bus_a.upd_valid), 0);
    chk("rst_upd_tgt",  32'(bus_a.upd_target), 0);
    chk("rst_brcnt",    32'(bus_a.branch_cnt), 0);
    chk("rst_miscnt",   32'(bus_a.mispred_cnt), 0);
    rst = 1'b1;
    tick();

    // Table: inject one instruction, bring it to EX, resolve, then let any squash drain
    exp_br = 0; exp_mis = 0;
    for (int i = 0; i < 10; i++) begin
      if_valid = tbl[i].iv; if_pc = tbl[i].pc;
      pred_taken = tbl[i].pt; pred_target = tbl[i].ptgt;
      tick();
      if_valid = 1'b0;
      tick();
      ex_is_branch = tbl[i].br; ex_taken = tbl[i].et; ex_target = tbl[i].etgt;
      tick();
      $display("vec %0d pc=%02h flush=%0b rpc=%02h upd=%0b utk=%0b utgt=%02h", i, tbl[i].pc,
               bus_a.flush, bus_a.redirect_pc, bus_a.upd_valid, bus_a.upd_taken, bus_a.upd_target);
      chk($sformatf("v%0d_upd_v", i),   32'(bus_a.upd_valid), 32'(tbl[i].e_upd));
      chk($sformatf("v%0d_flush", i),   32'(bus_a.flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_redir_v", i), 32'(bus_a.redirect_valid), 32'(tbl[i].e_flush));
      if (tbl[i].e_upd) begin
        chk($sformatf("v%0d_upd_pc", i),  32'(bus_a.upd_pc), 32'(tbl[i].pc));
        chk($sformatf("v%0d_upd_tk", i),  32'(bus_a.upd_taken), 32'(tbl[i].et));
        chk($sformatf("v%0d_upd_tgt", i), 32'(bus_a.upd_target), 32'(tbl[i].etgt));
      end
      if (tbl[i].e_flush)
        chk($sformatf("v%0d_redir_pc", i), 32'(bus_a.redirect_pc), 32'(tbl[i].e_rpc));
      exp_br  += int'(tbl[i].e_upd);
      exp_mis += int'(tbl[i].e_flush);
      ex_is_branch = 1'b0;
      tick();
      chk($sformatf("v%0d_flush_drop", i), 32'(bus_a.flush), 0);
      chk($sformatf("v%0d_upd_drop", i),   32'(bus_a.upd_valid), 0);
      repeat (5) tick();
    end
    chk("tbl_brcnt",  32'(bus_a.branch_cnt), 32'(exp_br));
    chk("tbl_miscnt", 32'(bus_a.mispred_cnt), 32'(exp_mis));
    chk("tbl_brcnt_abs",  32'(bus_a.branch_cnt), 8);
    chk("tbl_miscnt_abs", 32'(bus_a.mispred_cnt), 4);

    // Stall with a correctly predicted branch sitting in EX
    if_valid = 1'b1; if_pc = 8'h10; pred_taken = 1'b1; pred_target = 8'h40;
    tick();
    if_valid = 1'b0;
    tick();
    ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 8'h40; stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      $display("stall %0d upd=%0b flush=%0b", s, bus_a.upd_valid, bus_a.flush);
      chk($sformatf("stall%0d_upd_v", s), 32'(bus_a.upd_valid), 0);
      chk($sformatf("stall%0d_flush", s), 32'(bus_a.flush), 0);
    end
    stall = 1'b0;
    tick();
    $display("stall release upd=%0b pc=%02h", bus_a.upd_valid, bus_a.upd_pc);
    chk("rel_upd_v",  32'(bus_a.upd_valid), 1);
    chk("rel_upd_pc", 32'(bus_a.upd_pc), 32'h10);
    chk("rel_flush",  32'(bus_a.flush), 0);
    ex_is_branch = 1'b0;
    tick();
    chk("rel_upd_drop", 32'(bus_a.upd_valid), 0);
    chk("rel_brcnt",  32'(bus_a.branch_cnt), 9);
    chk("rel_miscnt", 32'(bus_a.mispred_cnt), 4);

    // Stream of always-mispredicting branches from reset: squash windows and saturation
    rst = 1'b0;
    tick();
    if_valid = 1'b1; if_pc = 8'h20; pred_taken = 1'b1; pred_target = 8'h80;
    ex_is_branch = 1'b1; ex_taken = 1'b0; ex_target = 8'h80;
    rst = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      tick();
      ea = (k >= 3) && ((k - 3) % 3 == 0);
      eb = (k >= 3) && ((k - 3) % 5 == 0);
      $display("stream k=%0d flush_a=%0b flush_b=%0b", k, bus_a.flush, bus_b.flush);
      chk($sformatf("strm%0d_flush_a", k), 32'(bus_a.flush), 32'(ea));
      chk($sformatf("strm%0d_flush_b", k), 32'(bus_b.flush), 32'(eb));
      chk($sformatf("strm%0d_upd_b", k),   32'(bus_b.upd_valid), 32'(eb));
      if (ea) chk($sformatf("strm%0d_rpc_a", k), 32'(bus_a.redirect_pc), 32'h24);
    end
    chk("sat_brcnt_b",  32'(bus_b.branch_cnt), 7);
    chk("sat_miscnt_b", 32'(bus_b.mispred_cnt), 7);
    chk("strm_brcnt_a", 32'(bus_a.branch_cnt), 13);
    chk("strm_miscnt_a", 32'(bus_a.mispred_cnt), 13);

    // Asynchronous reset while the flush strobe is up and the FSM is squashing
    rst = 1'b0;
    #2;
    $display("async reset flush=%0b upd=%0b brcnt=%0d", bus_a.flush, bus_a.upd_valid, bus_a.branch_cnt);
    chk("arst_flush",   32'(bus_a.flush), 0);
    chk("arst_redir_v", 32'(bus_a.redirect_valid), 0);
    chk("arst_upd_v",   32'(bus_a.upd_valid), 0);
    chk("arst_brcnt",   32'(bus_a.branch_cnt), 0);
    chk("arst_miscnt",  32'(bus_a.mispred_cnt), 0);
    chk("arst_brcnt_b", 32'(bus_b.branch_cnt), 0);

    // After reset: RUN immediately; stall inside the squash window stretches it by 3 cycles
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      stall = (k >= 4) && (k <= 6);
      tick();
      ea = (k == 3) || (k == 9);
      $display("sqstall k=%0d stall=%0b flush_a=%0b", k, stall, bus_a.flush);
      chk($sformatf("sqst%0d_flush_a", k), 32'(bus_a.flush), 32'(ea));
    end
    stall = 1'b0;
    chk("sqst_miscnt_a", 32'(bus_a.mispred_cnt), 2);
    chk("sqst_brcnt_a",  32'(bus_a.branch_cnt), 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
